// File: rtl/usb_phy_pkg.sv
// Shared encodings for the oversampling USB full-speed receive front end.
package usb_phy_pkg;

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_J   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_DATA = 3'd2,
        ST_EOP  = 3'd3,
        ST_ERR  = 3'd4
    } rx_state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_STUFF = 2'b01;
    localparam logic [1:0] ERR_EOP   = 2'b10;

    localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;
    localparam logic [4:0] SYNC_TIMEOUT = 5'd16;

    // SE1 is folded into SE0 so downstream logic only ever sees J, K or SE0.
    function automatic logic [1:0] decode_line(input logic dp, input logic dn);
        logic [1:0] ls;
        case ({dp, dn})
            2'b10:   ls = LS_J;
            2'b01:   ls = LS_K;
            default: ls = LS_SE0;
        endcase
        return ls;
    endfunction

endpackage

// File: rtl/usb_rx_dpll.sv
// Synchronises D+/D-, decodes the line state and recovers the bit sampling point.
module usb_rx_dpll #(
    parameter int OVERSAMPLE = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       dp_i,
    input  logic       dn_i,
    output logic       sample_stb,
    output logic [1:0] line_state
);
    import usb_phy_pkg::*;

    localparam int              PH_W      = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(OVERSAMPLE / 2 - 1);

    logic [1:0]      meta_q;
    logic [1:0]      sync_q;
    logic [1:0]      ls_prev_q;
    logic [1:0]      ls_prev_d;
    logic [PH_W-1:0] phase_q;
    logic [PH_W-1:0] phase_d;
    logic [1:0]      ls_s;

    // Phase counter restarts on every edge so the sample lands mid-bit.
    always_comb begin
        ls_s      = decode_line(sync_q[1], sync_q[0]);
        ls_prev_d = ls_s;
        if (ls_s != ls_prev_q) begin
            phase_d = '0;
        end else if (phase_q == PH_LAST) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + PH_W'(1);
        end
    end

    // Synchroniser resets to the idle J level so reset release is not seen as an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q    <= 2'b10;
            sync_q    <= 2'b10;
            ls_prev_q <= LS_J;
            phase_q   <= '0;
        end else begin
            meta_q    <= {dp_i, dn_i};
            sync_q    <= meta_q;
            ls_prev_q <= ls_prev_d;
            phase_q   <= phase_d;
        end
    end

    assign sample_stb = (phase_q == PH_SAMPLE);
    assign line_state = ls_s;

endmodule

// File: rtl/usb_phy_rx.sv
// USB 1.1 full-speed receive front end: NRZI decode, unstuffing, SYNC/EOP framing
// and byte assembly on top of the oversampling DPLL.
module usb_phy_rx
    import usb_phy_pkg::*;
#(
    parameter int OVERSAMPLE = 4,
    parameter int BYTE_W     = 8,
    parameter int CNT_W      = 10,
    parameter int STUFF_LEN  = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_en_i,
    input  logic              dp_i,
    input  logic              dn_i,
    output logic [BYTE_W-1:0] byte_o,
    output logic              byte_valid_o,
    output logic              pkt_active_o,
    output logic              eop_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic [CNT_W-1:0]  byte_cnt_o
);

    localparam int              BC_W      = $clog2(BYTE_W + 1);
    localparam int              OC_W      = $clog2(STUFF_LEN + 1);
    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(BYTE_W - 1);
    localparam logic [OC_W-1:0] ONES_MAX  = OC_W'(STUFF_LEN);

    logic       sample_stb_s;
    logic [1:0] line_state_s;
    logic       dec_bit_s;
    logic       is_se0_s;

    rx_state_e         state_q,      state_d;
    logic [1:0]        prev_ls_q,    prev_ls_d;
    logic [OC_W-1:0]   ones_q,       ones_d;
    logic [7:0]        sync_win_q,   sync_win_d;
    logic [4:0]        sync_cnt_q,   sync_cnt_d;
    logic [BYTE_W-1:0] shift_q,      shift_d;
    logic [BC_W-1:0]   bit_cnt_q,    bit_cnt_d;
    logic              se0_seen_q,   se0_seen_d;
    logic [BYTE_W-1:0] byte_q,       byte_d;
    logic              byte_valid_q, byte_valid_d;
    logic              pkt_active_q, pkt_active_d;
    logic              eop_q,        eop_d;
    logic              err_q,        err_d;
    logic [1:0]        err_code_q,   err_code_d;
    logic [CNT_W-1:0]  byte_cnt_q,   byte_cnt_d;

    usb_rx_dpll #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_dpll (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .dp_i       (dp_i),
        .dn_i       (dn_i),
        .sample_stb (sample_stb_s),
        .line_state (line_state_s)
    );

    // Next-state logic: everything advances only on a sample strobe.
    always_comb begin
        state_d      = state_q;
        prev_ls_d    = prev_ls_q;
        ones_d       = ones_q;
        sync_win_d   = sync_win_q;
        sync_cnt_d   = sync_cnt_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        se0_seen_d   = se0_seen_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        pkt_active_d = pkt_active_q;
        eop_d        = 1'b0;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        byte_cnt_d   = byte_cnt_q;

        is_se0_s  = (line_state_s == LS_SE0);
        dec_bit_s = (line_state_s == prev_ls_q);

        // SE0 is not a bit, so it never becomes the NRZI reference.
        if (sample_stb_s && !is_se0_s) begin
            prev_ls_d = line_state_s;
        end else begin
            prev_ls_d = prev_ls_q;
        end

        if (!rx_en_i) begin
            state_d      = ST_IDLE;
            pkt_active_d = 1'b0;
        end else if (sample_stb_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (line_state_s == LS_K) begin
                        state_d    = ST_SYNC;
                        byte_cnt_d = '0;
                        // Pre-filled ones keep the window from matching before 8 real bits.
                        sync_win_d = {dec_bit_s, 7'h7F};
                        sync_cnt_d = 5'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SYNC: begin
                    if (is_se0_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        sync_win_d = {dec_bit_s, sync_win_q[7:1]};
                        if ({dec_bit_s, sync_win_q[7:1]} == SYNC_PATTERN) begin
                            state_d      = ST_DATA;
                            pkt_active_d = 1'b1;
                            ones_d       = '0;
                            bit_cnt_d    = '0;
                        end else if (sync_cnt_q == SYNC_TIMEOUT - 5'd1) begin
                            state_d = ST_IDLE;
                        end else begin
                            sync_cnt_d = sync_cnt_q + 5'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (is_se0_s) begin
                        state_d = ST_EOP;
                        if (bit_cnt_q != '0) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_EOP;
                        end else begin
                            err_d = 1'b0;
                        end
                    end else if (ones_q == ONES_MAX) begin
                        if (dec_bit_s) begin
                            state_d      = ST_ERR;
                            err_d        = 1'b1;
                            err_code_d   = ERR_STUFF;
                            pkt_active_d = 1'b0;
                            se0_seen_d   = 1'b0;
                        end else begin
                            ones_d = '0;
                        end
                    end else begin
                        shift_d = {dec_bit_s, shift_q[BYTE_W-1:1]};
                        ones_d  = dec_bit_s ? ones_q + OC_W'(1) : '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d    = '0;
                            byte_d       = {dec_bit_s, shift_q[BYTE_W-1:1]};
                            byte_valid_d = 1'b1;
                            if (byte_cnt_q != {CNT_W{1'b1}}) begin
                                byte_cnt_d = byte_cnt_q + CNT_W'(1);
                            end else begin
                                byte_cnt_d = byte_cnt_q;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + BC_W'(1);
                        end
                    end
                end
                ST_EOP: begin
                    if (line_state_s == LS_J) begin
                        state_d      = ST_IDLE;
                        eop_d        = 1'b1;
                        pkt_active_d = 1'b0;
                    end else begin
                        state_d = ST_EOP;
                    end
                end
                ST_ERR: begin
                    if (is_se0_s) begin
                        se0_seen_d = 1'b1;
                    end else if (se0_seen_q && (line_state_s == LS_J)) begin
                        state_d    = ST_IDLE;
                        se0_seen_d = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    pkt_active_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            prev_ls_q    <= LS_J;
            ones_q       <= '0;
            sync_win_q   <= '0;
            sync_cnt_q   <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            se0_seen_q   <= 1'b0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            pkt_active_q <= 1'b0;
            eop_q        <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            byte_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            prev_ls_q    <= prev_ls_d;
            ones_q       <= ones_d;
            sync_win_q   <= sync_win_d;
            sync_cnt_q   <= sync_cnt_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            se0_seen_q   <= se0_seen_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            pkt_active_q <= pkt_active_d;
            eop_q        <= eop_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            byte_cnt_q   <= byte_cnt_d;
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = byte_valid_q;
    assign pkt_active_o = pkt_active_q;
    assign eop_o        = eop_q;
    assign err_o        = err_q;
    assign err_code_o   = err_code_q;
    assign byte_cnt_o   = byte_cnt_q;

endmodule

// File: tb/tb_usb_phy_rx.sv
// Directed bench for usb_phy_rx: NRZI/stuffing transmitter model plus a strobe logger.
module tb_usb_phy_rx;

    localparam int OS = 4;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       rx_en_i;
    logic       dp_i;
    logic       dn_i;
    logic [7:0] byte_o;
    logic       byte_valid_o;
    logic       pkt_active_o;
    logic       eop_o;
    logic       err_o;
    logic [1:0] err_code_o;
    logic [9:0] byte_cnt_o;

    int         checks = 0;
    int         errors = 0;
    int         n_bytes = 0;
    int         n_eop = 0;
    int         n_err = 0;
    logic [1:0] last_err_code = 2'b00;
    logic [7:0] byte_log [32];

    bit tb_k = 1'b0;
    int tb_ones = 0;
    bit drift_en = 1'b0;
    bit drift_long = 1'b0;
    int b0, e0, r0;

    usb_phy_rx #(
        .OVERSAMPLE(OS),
        .BYTE_W    (8),
        .CNT_W     (10),
        .STUFF_LEN (6)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_en_i      (rx_en_i),
        .dp_i         (dp_i),
        .dn_i         (dn_i),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid_o),
        .pkt_active_o (pkt_active_o),
        .eop_o        (eop_o),
        .err_o        (err_o),
        .err_code_o   (err_code_o),
        .byte_cnt_o   (byte_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Strobe logger: each one-cycle strobe is seen on exactly one falling edge.
    always @(negedge clk_i) begin
        if (byte_valid_o) begin
            if (n_bytes < 32) byte_log[n_bytes[4:0]] <= byte_o;
            n_bytes <= n_bytes + 1;
        end
        if (eop_o) n_eop <= n_eop + 1;
        if (err_o) begin
            n_err         <= n_err + 1;
            last_err_code <= err_code_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] logged(input int idx);
        return byte_log[idx[4:0]];
    endfunction

    task automatic hold_level(input logic dp, input logic dn);
        int clks;
        dp_i = dp;
        dn_i = dn;
        clks = OS;
        if (drift_en) begin
            drift_long = ~drift_long;
            clks = drift_long ? 5 : 3;
        end
        repeat (clks) @(negedge clk_i);
    endtask

    task automatic send_bit(input bit b);
        if (!b) tb_k = ~tb_k;
        hold_level(~tb_k, tb_k);
    endtask

    task automatic send_sync();
        tb_ones = 0;
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            send_bit(v[i]);
            if (v[i]) tb_ones++;
            else tb_ones = 0;
            if (tb_ones == 6) begin
                send_bit(1'b0);
                tb_ones = 0;
            end
        end
    endtask

    task automatic send_se0(input int nbits);
        for (int i = 0; i < nbits; i++) hold_level(1'b0, 1'b0);
        tb_k = 1'b0;
    endtask

    task automatic send_idle(input int nbits);
        tb_k = 1'b0;
        for (int i = 0; i < nbits; i++) hold_level(1'b1, 1'b0);
    endtask

    task automatic snap();
        b0 = n_bytes;
        e0 = n_eop;
        r0 = n_err;
    endtask

    initial begin
        rst_i   = 1'b1;
        rx_en_i = 1'b1;
        dp_i    = 1'b1;
        dn_i    = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_byte",     32'(byte_o), 32'h0);
        check("rst_bvalid",   32'(byte_valid_o), 32'h0);
        check("rst_active",   32'(pkt_active_o), 32'h0);
        check("rst_eop",      32'(eop_o), 32'h0);
        check("rst_err",      32'(err_o), 32'h0);
        check("rst_code",     32'(err_code_o), 32'h0);
        check("rst_cnt",      32'(byte_cnt_o), 32'h0);
        rst_i = 1'b0;
        send_idle(8);

        // SYNC + 0xA5 + EOP, with exact eop_o latency after the J edge
        snap();
        send_sync();
        send_byte(8'hA5);
        send_se0(2);
        check("a5_active_in_eop", 32'(pkt_active_o), 32'h1);
        dp_i = 1'b1;
        dn_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check("a5_eop_early", 32'(eop_o), 32'h0);
        @(negedge clk_i);
        check("a5_eop_on_time", 32'(eop_o), 32'h1);
        send_idle(8);
        check("a5_nbytes", 32'(n_bytes - b0), 32'd1);
        check("a5_byte",   32'(logged(b0)), 32'hA5);
        check("a5_cnt",    32'(byte_cnt_o), 32'd1);
        check("a5_neop",   32'(n_eop - e0), 32'd1);
        check("a5_nerr",   32'(n_err - r0), 32'd0);
        check("a5_idle",   32'(pkt_active_o), 32'h0);

        // 0xFF (one stuffed zero) then 0x7E (stuffed zero before its final 0)
        snap();
        send_sync();
        send_byte(8'hFF);
        send_byte(8'h7E);
        send_se0(2);
        send_idle(8);
        check("ff_nbytes", 32'(n_bytes - b0), 32'd2);
        check("ff_byte0",  32'(logged(b0)), 32'hFF);
        check("ff_byte1",  32'(logged(b0 + 1)), 32'h7E);
        check("ff_cnt",    32'(byte_cnt_o), 32'd2);
        check("ff_nerr",   32'(n_err - r0), 32'd0);
        check("ff_neop",   32'(n_eop - e0), 32'd1);

        // Seven 1s without a stuffed zero
        snap();
        send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        send_se0(2);
        check("stuff_active", 32'(pkt_active_o), 32'h0);
        check("stuff_nerr",   32'(n_err - r0), 32'd1);
        check("stuff_code",   32'(last_err_code), 32'h1);
        send_idle(8);
        check("stuff_neop",   32'(n_eop - e0), 32'd0);
        check("stuff_hold",   32'(err_code_o), 32'h1);
        check("stuff_nbytes", 32'(n_bytes - b0), 32'd0);
        snap();
        send_sync();
        send_byte(8'h3C);
        send_se0(2);
        send_idle(8);
        check("recov_byte", 32'(logged(b0)), 32'h3C);
        check("recov_cnt",  32'(byte_cnt_o), 32'd1);
        check("recov_neop", 32'(n_eop - e0), 32'd1);
        check("recov_nerr", 32'(n_err - r0), 32'd0);

        // 0x12 followed by 3 stray bits before SE0
        snap();
        send_sync();
        send_byte(8'h12);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_se0(2);
        send_idle(8);
        check("mis_nbytes", 32'(n_bytes - b0), 32'd1);
        check("mis_byte",   32'(logged(b0)), 32'h12);
        check("mis_nerr",   32'(n_err - r0), 32'd1);
        check("mis_code",   32'(last_err_code), 32'h2);
        check("mis_neop",   32'(n_eop - e0), 32'd1);
        check("mis_cnt",    32'(byte_cnt_o), 32'd1);

        // Transmitter bit period alternating 3/5 clocks
        snap();
        drift_en = 1'b1;
        send_sync();
        send_byte(8'hC3);
        send_se0(2);
        send_idle(2);
        drift_en = 1'b0;
        send_idle(6);
        check("drift_nbytes", 32'(n_bytes - b0), 32'd1);
        check("drift_byte",   32'(logged(b0)), 32'hC3);
        check("drift_neop",   32'(n_eop - e0), 32'd1);
        check("drift_nerr",   32'(n_err - r0), 32'd0);

        // Drop rx_en_i in the middle of a byte
        snap();
        send_sync();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("abort_active_before", 32'(pkt_active_o), 32'h1);
        rx_en_i = 1'b0;
        @(negedge clk_i);
        check("abort_active_next", 32'(pkt_active_o), 32'h0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_se0(2);
        send_idle(8);
        check("abort_nbytes", 32'(n_bytes - b0), 32'd0);
        check("abort_neop",   32'(n_eop - e0), 32'd0);
        check("abort_nerr",   32'(n_err - r0), 32'd0);
        check("abort_hold",   32'(byte_o), 32'hC3);
        rx_en_i = 1'b1;
        send_idle(4);

        // Reset asserted mid-packet
        snap();
        send_sync();
        send_byte(8'h81);
        send_bit(1'b0);
        send_bit(1'b1);
        check("mrst_active_before", 32'(pkt_active_o), 32'h1);
        check("mrst_cnt_before",    32'(byte_cnt_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check("mrst_byte",   32'(byte_o), 32'h0);
        check("mrst_active", 32'(pkt_active_o), 32'h0);
        check("mrst_cnt",    32'(byte_cnt_o), 32'h0);
        check("mrst_code",   32'(err_code_o), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_se0(2);
        send_idle(8);
        check("mrst_nbytes", 32'(n_bytes - b0), 32'd1);
        check("mrst_neop",   32'(n_eop - e0), 32'd0);
        check("mrst_nerr",   32'(n_err - r0), 32'd0);
        check("mrst_cnt_after", 32'(byte_cnt_o), 32'h0);

        snap();
        send_sync();
        send_byte(8'h5A);
        send_se0(2);
        send_idle(8);
        check("post_byte", 32'(logged(b0)), 32'h5A);
        check("post_neop", 32'(n_eop - e0), 32'd1);
        check("post_cnt",  32'(byte_cnt_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
